boe_feeder: RTL and testbench
=============================

# boe_feeder

Upstream batching stage for the BOE statistics block. Accepts a byte stream from the host over a valid/ready handshake, buffers complete batches of 1–6 bytes, and replays each batch into BOE as a single-cycle nonzero `data_num` followed by the batch bytes on `data_in`. After each batch it holds BOE's inputs idle until BOE has finished emitting max, sum and the sorted values.

## Interface
- `BYTE_DEPTH`, default 16: byte FIFO depth; a power of 2, at least 8.
- `LEN_DEPTH`, default 4: batch-length FIFO depth; a power of 2.
- `GAP_EXTRA`, default 2: BOE output-phase cycles beyond N (the max and sum slots).
- `clk` in 1: single clock, rising edge.
- `rst` in 1: reset; synchronous, active-high.
- `in_valid` in 1: host byte valid.
- `in_ready` out 1: byte accepted on `in_valid && in_ready`.
- `in_data` in 8: host byte.
- `in_last` in 1: marks the final byte of a batch.
- `data_num` out 3: batch length N (1–6) on the first byte cycle only; 0 otherwise. Drives BOE `data_num`.
- `data_in` out 8: batch byte during FEED; 0 otherwise. Drives BOE `data_in`.
- `boe_busy` out 1: high during FEED and DRAIN.
- `err_overlong` out 1: one-cycle pulse when a batch is truncated at 6 bytes.

## Operation
- Byte FIFO and length FIFO:
  - Each accepted byte is pushed into the byte FIFO.
  - An accept counter `acc_cnt` (0–5) counts bytes of the batch in progress.
  - The batch commits when the accepted byte has `in_last=1` or `acc_cnt==5`. On commit, push `acc_cnt+1` into the length FIFO and clear `acc_cnt`.
  - If the commit is due to `acc_cnt==5` with `in_last=0`, pulse `err_overlong` on the next cycle. The next byte starts a new batch.
- `in_ready` = byte FIFO not full AND length FIFO not full. Both conditions are evaluated on registered occupancy; there is no same-cycle pop bypass.
- A simultaneous push and pop on either FIFO is legal. Occupancy is then unchanged.
- FSM states are IDLE, FEED and DRAIN.
  - IDLE: if the length FIFO is non-empty, pop N, load `feed_cnt=N`, and go to FEED.
  - FEED: pop one byte per cycle and decrement `feed_cnt`. At the last byte, load `drain_cnt = N + GAP_EXTRA` and go to DRAIN.
  - DRAIN: decrement `drain_cnt`. Go to IDLE when it reaches 1.
- Only committed batches are fed. A partial batch in the byte FIFO is never read.
- `data_num`/`data_in` are registered outputs:
  - First FEED cycle: `data_num=N`, `data_in`=byte0.
  - Following cycles: `data_num=0`, `data_in`=byte k.
  - DRAIN/IDLE: both 0.
- Widths:
  - `acc_cnt` and `feed_cnt` are 3 bits.
  - `drain_cnt` is 4 bits; its maximum is 6+GAP_EXTRA, so GAP_EXTRA ≤ 9.
  - FIFO pointers are log2(depth)+1 bits and wrap naturally.
- Reset:
  - All outputs go to 0, including `in_ready=0` while `rst` is high. `in_ready` is 1 the first cycle after release.
  - Both FIFOs are flushed, `acc_cnt` is cleared, and the FSM goes to IDLE.
  - Reset during FEED/DRAIN drops the batch. Outputs are 0 the cycle after `rst` is sampled.

## Timing
- Latency: a batch whose last byte is accepted at edge t (FSM idle, FIFOs empty) shows `data_num=N` at edge t+2. That is one cycle of length-FIFO commit plus one cycle of IDLE decision.
- The batch occupies N FEED cycles, then N+GAP_EXTRA DRAIN cycles, then one IDLE cycle.
- Back-to-back batches: first bytes are spaced exactly 2N+GAP_EXTRA+1 cycles apart, with N being the earlier batch's length.
- `boe_busy` is registered and aligned with the `data_num`/`data_in` outputs.
- `err_overlong` asserts on the cycle after the 6th byte is accepted, for one cycle.
- Host side: `in_data`/`in_last` are sampled only on handshake cycles. `in_valid` may toggle freely.

## Test plan
- Single batch 10,20,5 with `in_last` on 5 → `data_num` 3,0,0 with `data_in` 10,20,5 on consecutive cycles; then 5 zero cycles with `boe_busy=1`; then `boe_busy=0`.
- N=1, byte 255 → one cycle with `data_num=1`, `data_in=255`; 3 DRAIN cycles; `err_overlong` stays 0.
- Two queued batches (1,2,3,4 then 9,8) → second `data_num=2` appears exactly 11 cycles after first `data_num=4`; byte order is preserved.
- Eight bytes 1..8 with `in_last` only on 8 → first batch N=6 (1..6) and one `err_overlong` pulse; second batch N=2 (7,8).
- Host pushes continuously while the feeder is stalled in DRAIN → `in_ready` drops when the byte FIFO reaches 16 or 4 lengths are queued. No byte is lost or duplicated across the wrap-around of the FIFO pointers.
- Assert `rst` for one cycle mid-FEED of 4,4,4,4 → outputs are 0 the next cycle and `in_ready=1` after release. A new batch 7 then emits `data_num=1`, `data_in=7`, with no residue from the dropped batch.

Source files
------------

// File: rtl/boe_feeder.sv
// boe_feeder: buffers host bytes into committed batches of 1-6
// and replays each batch into BOE, then idles through BOE's output phase.
module boe_feeder #(
   parameter int BYTE_DEPTH = 16,
   parameter int LEN_DEPTH  = 4,
   parameter int GAP_EXTRA  = 2
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       in_valid,
   output logic       in_ready,
   input  logic [7:0] in_data,
   input  logic       in_last,
   output logic [2:0] data_num,
   output logic [7:0] data_in,
   output logic       boe_busy,
   output logic       err_overlong
);

   localparam int BAW = $clog2(BYTE_DEPTH);
   localparam int LAW = $clog2(LEN_DEPTH);

   localparam logic [BAW:0] B_ONE   = (BAW+1)'(1);
   localparam logic [LAW:0] L_ONE   = (LAW+1)'(1);
   localparam logic [BAW:0] B_DEPTH = (BAW+1)'(BYTE_DEPTH);
   localparam logic [LAW:0] L_DEPTH = (LAW+1)'(LEN_DEPTH);
   localparam logic [3:0]   GAP     = 4'(GAP_EXTRA);

   typedef enum logic [1:0] {
      IDLE,
      FEED,
      DRAIN
   } state_t;

   logic [7:0] byte_mem [BYTE_DEPTH];
   logic [2:0] len_mem  [LEN_DEPTH];

   logic [BAW:0] b_wr;
   logic [BAW:0] b_rd;
   logic [LAW:0] l_wr;
   logic [LAW:0] l_rd;

   logic b_full;
   logic l_full;
   logic l_empty;
   logic accept;
   logic commit;

   logic [2:0] acc_cnt;
   logic [2:0] feed_cnt;
   logic [2:0] n_q;
   logic [3:0] drain_cnt;
   state_t     state;

   // Occupancy is pointer distance; the extra MSB tells full from empty.
   assign b_full  = ((b_wr - b_rd) == B_DEPTH);
   assign l_full  = ((l_wr - l_rd) == L_DEPTH);
   assign l_empty = (l_wr == l_rd);

   // No pop bypass: a full FIFO refuses even if it drains this cycle.
   assign in_ready = !rst && !b_full && !l_full;
   assign accept   = in_valid && in_ready;
   assign commit   = accept && (in_last || acc_cnt == 3'd5);

   // Storage writes for accepted bytes and committed batch lengths.
   always_ff @(posedge clk) begin
      if (accept)
         byte_mem[b_wr[BAW-1:0]] <= in_data;
      if (commit)
         len_mem[l_wr[LAW-1:0]] <= acc_cnt + 3'd1;
   end

   // Host side: write pointers, batch byte count, truncation flag.
   always_ff @(posedge clk) begin
      if (rst) begin
         b_wr         <= '0;
         l_wr         <= '0;
         acc_cnt      <= '0;
         err_overlong <= 1'b0;
      end else begin
         err_overlong <= commit && !in_last;
         if (accept)
            b_wr <= b_wr + B_ONE;
         if (commit) begin
            l_wr    <= l_wr + L_ONE;
            acc_cnt <= '0;
         end else if (accept) begin
            acc_cnt <= acc_cnt + 3'd1;
         end
      end
   end

   // Feed FSM: pop a length, replay its bytes, then wait out BOE.
   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         b_rd      <= '0;
         l_rd      <= '0;
         feed_cnt  <= '0;
         n_q       <= '0;
         drain_cnt <= '0;
         data_num  <= '0;
         data_in   <= '0;
         boe_busy  <= 1'b0;
      end else begin
         data_num <= '0;
         data_in  <= '0;
         boe_busy <= 1'b0;
         unique case (state)
            IDLE: begin
               if (!l_empty) begin
                  n_q      <= len_mem[l_rd[LAW-1:0]];
                  feed_cnt <= len_mem[l_rd[LAW-1:0]];
                  l_rd     <= l_rd + L_ONE;
                  state    <= FEED;
               end
            end
            FEED: begin
               boe_busy <= 1'b1;
               data_in  <= byte_mem[b_rd[BAW-1:0]];
               data_num <= (feed_cnt == n_q) ? n_q : 3'd0;
               b_rd     <= b_rd + B_ONE;
               feed_cnt <= feed_cnt - 3'd1;
               if (feed_cnt == 3'd1) begin
                  drain_cnt <= {1'b0, n_q} + GAP;
                  state     <= DRAIN;
               end
            end
            DRAIN: begin
               boe_busy  <= 1'b1;
               drain_cnt <= drain_cnt - 4'd1;
               if (drain_cnt == 4'd1)
                  state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_boe_feeder.sv
// tb_boe_feeder: directed checks of batching, timing,
// truncation, back-pressure and reset for boe_feeder.
module tb_boe_feeder;

   localparam int LOGN = 4000;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       in_valid = 1'b0;
   logic       in_ready;
   logic [7:0] in_data = 8'd0;
   logic       in_last = 1'b0;
   logic [2:0] data_num;
   logic [7:0] data_in;
   logic       boe_busy;
   logic       err_overlong;

   int checks = 0;
   int errors = 0;
   int cyc = 0;

   logic [2:0] lg_num [0:LOGN+15];
   logic [7:0] lg_din [0:LOGN+15];
   logic       lg_err [0:LOGN+15];

   boe_feeder dut (
      .clk(clk),
      .rst(rst),
      .in_valid(in_valid),
      .in_ready(in_ready),
      .in_data(in_data),
      .in_last(in_last),
      .data_num(data_num),
      .data_in(data_in),
      .boe_busy(boe_busy),
      .err_overlong(err_overlong)
   );

   always #5 clk = ~clk;

   // Output trace, one entry per cycle, sampled mid-cycle.
   always @(negedge clk) begin
      if (cyc < LOGN) begin
         lg_num[cyc] <= data_num;
         lg_din[cyc] <= data_in;
         lg_err[cyc] <= err_overlong;
      end
      cyc <= cyc + 1;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   task automatic cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic send(input logic [7:0] d, input logic l, output int waited);
      int n;
      n = 0;
      in_valid = 1'b1;
      in_data  = d;
      in_last  = l;
      while (in_ready !== 1'b1 && n < 100) begin
         cycle();
         n++;
      end
      if (n >= 100)
         chk("send_timeout", n, 0);
      cycle();
      in_valid = 1'b0;
      in_last  = 1'b0;
      in_data  = 8'd0;
      waited   = n;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      cycle();
      cycle();
      rst = 1'b0;
      #1;
   endtask

   function automatic int find_num(int from, int upto);
      for (int i = from; i < upto && i < LOGN; i++)
         if (lg_num[i] != 3'd0)
            return i;
      return LOGN;
   endfunction

   initial begin
      int w, mk, mkerr, i1, i2, nb, nbat, cnt;
      int wt [1:48];
      logic [7:0] got [0:63];

      // reset state
      repeat (3) cycle();
      chk("rst_ready", in_ready, 0);
      chk("rst_num", data_num, 0);
      chk("rst_din", data_in, 0);
      chk("rst_busy", boe_busy, 0);
      chk("rst_err", err_overlong, 0);
      rst = 1'b0;
      #1;
      chk("release_ready", in_ready, 1);

      // single batch 10,20,5
      send(8'd10, 1'b0, w);
      send(8'd20, 1'b0, w);
      send(8'd5, 1'b1, w);
      cycle();
      chk("t1_pre_num", data_num, 0);
      cycle();
      chk("t1_num0", data_num, 3);
      chk("t1_din0", data_in, 10);
      chk("t1_busy0", boe_busy, 1);
      cycle();
      chk("t1_num1", data_num, 0);
      chk("t1_din1", data_in, 20);
      cycle();
      chk("t1_num2", data_num, 0);
      chk("t1_din2", data_in, 5);
      for (int k = 0; k < 5; k++) begin
         cycle();
         chk($sformatf("t1_drain_busy%0d", k), boe_busy, 1);
         chk($sformatf("t1_drain_din%0d", k), data_in, 0);
         chk($sformatf("t1_drain_num%0d", k), data_num, 0);
      end
      cycle();
      chk("t1_idle_busy", boe_busy, 0);

      // single byte batch 255
      send(8'd255, 1'b1, w);
      cycle();
      chk("t2_pre_num", data_num, 0);
      cycle();
      chk("t2_num", data_num, 1);
      chk("t2_din", data_in, 255);
      chk("t2_err", err_overlong, 0);
      for (int k = 0; k < 3; k++) begin
         cycle();
         chk($sformatf("t2_drain_busy%0d", k), boe_busy, 1);
         chk($sformatf("t2_drain_din%0d", k), data_in, 0);
         chk($sformatf("t2_drain_err%0d", k), err_overlong, 0);
      end
      cycle();
      chk("t2_idle_busy", boe_busy, 0);

      // two queued batches 1,2,3,4 and 9,8
      mk = cyc;
      send(8'd1, 1'b0, w);
      send(8'd2, 1'b0, w);
      send(8'd3, 1'b0, w);
      send(8'd4, 1'b1, w);
      send(8'd9, 1'b0, w);
      send(8'd8, 1'b1, w);
      repeat (40) cycle();
      i1 = find_num(mk, cyc);
      i2 = find_num(i1 + 1, cyc);
      chk("t3_num_a", lg_num[i1], 4);
      chk("t3_num_b", lg_num[i2], 2);
      chk("t3_gap", i2 - i1, 11);
      for (int k = 0; k < 4; k++)
         chk($sformatf("t3_byte_a%0d", k), lg_din[i1+k], k + 1);
      chk("t3_byte_b0", lg_din[i2], 9);
      chk("t3_byte_b1", lg_din[i2+1], 8);

      // eight bytes, last only on 8: truncation at 6
      mk = cyc;
      mkerr = 0;
      for (int v = 1; v <= 8; v++) begin
         send(8'(v), (v == 8), w);
         if (v == 6)
            mkerr = cyc;
      end
      repeat (40) cycle();
      cnt = 0;
      for (int i = mk; i < cyc; i++)
         if (lg_err[i] === 1'b1)
            cnt++;
      chk("t4_err_pulses", cnt, 1);
      chk("t4_err_time", lg_err[mkerr], 1);
      i1 = find_num(mk, cyc);
      i2 = find_num(i1 + 1, cyc);
      chk("t4_num_a", lg_num[i1], 6);
      chk("t4_num_b", lg_num[i2], 2);
      for (int k = 0; k < 6; k++)
         chk($sformatf("t4_byte_a%0d", k), lg_din[i1+k], k + 1);
      chk("t4_byte_b0", lg_din[i2], 7);
      chk("t4_byte_b1", lg_din[i2+1], 8);

      // length FIFO fills with 1-byte batches
      do_reset();
      mk = cyc;
      for (int k = 1; k <= 6; k++)
         send(8'(10 + k), 1'b1, wt[k]);
      for (int k = 1; k <= 5; k++)
         chk($sformatf("t5a_wait%0d", k), wt[k], 0);
      chk("t5a_wait6", wt[6], 2);
      repeat (60) cycle();
      nbat = 0;
      for (int i = mk; i < cyc; i++)
         if (lg_num[i] != 3'd0) begin
            nbat++;
            chk($sformatf("t5a_num%0d", nbat), lg_num[i], 1);
            chk($sformatf("t5a_byte%0d", nbat), lg_din[i], 10 + nbat);
         end
      chk("t5a_batches", nbat, 6);

      // byte FIFO fills with 6-byte batches, pointers wrap
      do_reset();
      mk = cyc;
      for (int k = 1; k <= 48; k++)
         send(8'(k), (k % 6 == 0), wt[k]);
      cnt = 0;
      for (int k = 1; k <= 22; k++)
         if (wt[k] != 0)
            cnt++;
      chk("t5b_early_stalls", cnt, 0);
      chk("t5b_wait23", wt[23], 1);
      repeat (80) cycle();
      nb = 0;
      nbat = 0;
      for (int i = mk; i < cyc; i++)
         if (lg_num[i] != 3'd0 && nb <= 58) begin
            nbat++;
            chk($sformatf("t5b_len%0d", nbat), lg_num[i], 6);
            for (int k = 0; k < 6; k++) begin
               got[nb] = lg_din[i+k];
               nb++;
            end
         end
      chk("t5b_batches", nbat, 8);
      for (int k = 0; k < 48; k++)
         chk($sformatf("t5b_byte%0d", k), got[k], k + 1);

      // reset mid-FEED drops the batch
      do_reset();
      send(8'd4, 1'b0, w);
      send(8'd4, 1'b0, w);
      send(8'd4, 1'b0, w);
      send(8'd4, 1'b1, w);
      cycle();
      chk("t6_pre_num", data_num, 0);
      cycle();
      chk("t6_num", data_num, 4);
      chk("t6_din", data_in, 4);
      rst = 1'b1;
      #1;
      chk("t6_rst_ready", in_ready, 0);
      cycle();
      chk("t6_rst_num", data_num, 0);
      chk("t6_rst_din", data_in, 0);
      chk("t6_rst_busy", boe_busy, 0);
      rst = 1'b0;
      #1;
      chk("t6_release_ready", in_ready, 1);
      mk = cyc;
      send(8'd7, 1'b1, w);
      repeat (20) cycle();
      cnt = 0;
      nb = 0;
      for (int i = mk; i < cyc; i++) begin
         if (lg_num[i] != 3'd0)
            cnt++;
         if (lg_din[i] != 8'd0)
            nb++;
      end
      chk("t6_batches", cnt, 1);
      chk("t6_nonzero_bytes", nb, 1);
      i1 = find_num(mk, cyc);
      chk("t6_new_num", lg_num[i1], 1);
      chk("t6_new_din", lg_din[i1], 7);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
